// File: rtl/ex_mem_stage_if.sv
// EX->MEM bundle: execute-stage inputs, MEM-stage registers,
// and the stall/busy feedback driven back toward the front end.
interface ex_mem_stage_if;
    logic [4:0]  ALUControlE;
    logic [31:0] ALUResultE;
    logic [31:0] WriteDataE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RD_E;
    logic        RegWriteE;
    logic        MemWriteE;
    logic [1:0]  ResultSrcE;
    logic        FlushE;

    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RD_M;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;

    logic        StallE;
    logic        MulBusy;

    modport master (
        output ALUControlE, ALUResultE, WriteDataE, PCPlus4E,
        output RD_E, RegWriteE, MemWriteE, ResultSrcE, FlushE,
        input  ALUResultM, WriteDataM, PCPlus4M,
        input  RD_M, RegWriteM, MemWriteM, ResultSrcM,
        input  StallE, MulBusy
    );

    modport slave (
        input  ALUControlE, ALUResultE, WriteDataE, PCPlus4E,
        input  RD_E, RegWriteE, MemWriteE, ResultSrcE, FlushE,
        output ALUResultM, WriteDataM, PCPlus4M,
        output RD_M, RegWriteM, MemWriteM, ResultSrcM,
        output StallE, MulBusy
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with multi-cycle multiply tracking.
// Multiplies hold EX and feed bubbles to MEM until the product is valid.
module ex_mem_stage #(
    parameter int MUL_LATENCY = 2
) (
    input logic            clk,
    input logic            rst,
    ex_mem_stage_if.slave  bus
);
    localparam int CW = $clog2(MUL_LATENCY) + 1;
    localparam bit MULTI = (MUL_LATENCY > 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_mul;
    logic          stall;
    logic          capture;

    assign is_mul = (bus.ALUControlE >= 5'b01010)
                 && (bus.ALUControlE <= 5'b01101);

    // Stall/capture decision; a redirect always beats a pending multiply.
    always_comb begin
        stall   = 1'b0;
        capture = 1'b0;
        if (!bus.FlushE) begin
            unique case (state)
                IDLE: begin
                    stall   = is_mul && MULTI;
                    capture = !(is_mul && MULTI);
                end
                WAIT: begin
                    stall   = (cnt != '0);
                    capture = (cnt == '0);
                end
            endcase
        end
    end

    assign bus.StallE  = stall & ~rst;
    assign bus.MulBusy = (state == WAIT);

    // Sequencer state plus MEM registers: capture EX or insert a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCPlus4M   <= '0;
            bus.RD_M       <= '0;
            bus.RegWriteM  <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ResultSrcM <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.FlushE && is_mul && MULTI) begin
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.FlushE) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase

            if (capture) begin
                bus.ALUResultM <= bus.ALUResultE;
                bus.WriteDataM <= bus.WriteDataE;
                bus.PCPlus4M   <= bus.PCPlus4E;
                bus.RD_M       <= bus.RD_E;
                bus.RegWriteM  <= bus.RegWriteE;
                bus.MemWriteM  <= bus.MemWriteE;
                bus.ResultSrcM <= bus.ResultSrcE;
            end else begin
                bus.ALUResultM <= '0;
                bus.WriteDataM <= '0;
                bus.PCPlus4M   <= '0;
                bus.RD_M       <= '0;
                bus.RegWriteM  <= 1'b0;
                bus.MemWriteM  <= 1'b0;
                bus.ResultSrcM <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: multiply stalls, flush,
// async reset mid-multiply, stores, and a single-cycle-multiply build.
module tb_ex_mem_stage;
    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHU  = 5'b01101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    ex_mem_stage_if b0 ();
    ex_mem_stage_if b1 ();

    ex_mem_stage #(.MUL_LATENCY(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    ex_mem_stage #(.MUL_LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] op, input logic [31:0] res,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw,
                         input logic mw, input logic [1:0] rs,
                         input logic fl);
        b0.ALUControlE = op;
        b0.ALUResultE  = res;
        b0.WriteDataE  = wd;
        b0.PCPlus4E    = pc;
        b0.RD_E        = rd;
        b0.RegWriteE   = rw;
        b0.MemWriteE   = mw;
        b0.ResultSrcE  = rs;
        b0.FlushE      = fl;
    endtask

    task automatic test_reset();
        drive(OP_MUL, 32'h55, 32'h66, 32'h77, 5'd9, 1'b1, 1'b1, 2'd1, 1'b0);
        #1;
        n_cmp++;
        if (b0.StallE !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall: got %b want 0", b0.StallE);
        end
        n_cmp++;
        if (b0.ALUResultM !== 32'h0 || b0.RD_M !== 5'd0
            || b0.RegWriteM !== 1'b0 || b0.MemWriteM !== 1'b0
            || b0.WriteDataM !== 32'h0 || b0.PCPlus4M !== 32'h0
            || b0.ResultSrcM !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got res=%h rd=%0d rw=%b want all 0",
                     b0.ALUResultM, b0.RD_M, b0.RegWriteM);
        end
        n_cmp++;
        if (b0.MulBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", b0.MulBusy);
        end
        drive(OP_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        drive(OP_MUL, 32'h1, 32'h0, 32'h10, 5'd4, 1'b1, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (b0.StallE !== 1'b1) begin
            n_bad++;
            $display("FAIL rmw_stall0: got %b want 1", b0.StallE);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (b0.MulBusy !== 1'b1) begin
            n_bad++;
            $display("FAIL rmw_busy: got %b want 1", b0.MulBusy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (b0.MulBusy !== 1'b0 || b0.StallE !== 1'b0) begin
            n_bad++;
            $display("FAIL rmw_async: got busy=%b stall=%b want 0 0",
                     b0.MulBusy, b0.StallE);
        end
        n_cmp++;
        if (b0.ALUResultM !== 32'h0 || b0.RegWriteM !== 1'b0) begin
            n_bad++;
            $display("FAIL rmw_outs: got res=%h rw=%b want 0 0",
                     b0.ALUResultM, b0.RegWriteM);
        end
        drive(OP_ADD, 32'd7, 32'h0, 32'h20, 5'd3, 1'b1, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (b0.ALUResultM !== 32'd7 || b0.RD_M !== 5'd3
            || b0.RegWriteM !== 1'b1) begin
            n_bad++;
            $display("FAIL rmw_add: got res=%0d rd=%0d rw=%b want 7 3 1",
                     b0.ALUResultM, b0.RD_M, b0.RegWriteM);
        end
    endtask

    task automatic test_single_mul();
        logic [31:0] res_seq [3];
        logic        stall_exp [3];
        res_seq[0] = 32'h111;
        res_seq[1] = 32'h222;
        res_seq[2] = 32'd42;
        stall_exp[0] = 1'b1;
        stall_exp[1] = 1'b1;
        stall_exp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(OP_MUL, res_seq[i], 32'h0, 32'h40, 5'd5, 1'b1, 1'b0,
                  2'd0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (b0.StallE !== stall_exp[i]) begin
                n_bad++;
                $display("FAIL mul_stall%0d: got %b want %b",
                         i, b0.StallE, stall_exp[i]);
            end
            @(posedge clk);
            #1;
            if (i < 2) begin
                n_cmp++;
                if (b0.RegWriteM !== 1'b0 || b0.ALUResultM !== 32'h0
                    || b0.RD_M !== 5'd0 || b0.PCPlus4M !== 32'h0) begin
                    n_bad++;
                    $display("FAIL mul_bubble%0d: got rw=%b res=%h want 0 0",
                             i, b0.RegWriteM, b0.ALUResultM);
                end
            end else begin
                n_cmp++;
                if (b0.ALUResultM !== 32'd42 || b0.RD_M !== 5'd5
                    || b0.RegWriteM !== 1'b1 || b0.PCPlus4M !== 32'h40
                    || b0.MulBusy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mul_capture: got res=%0d rd=%0d rw=%b busy=%b want 42 5 1 0",
                             b0.ALUResultM, b0.RD_M, b0.RegWriteM, b0.MulBusy);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(OP_ADD, 32'd10, 32'h0, 32'h100, 5'd1, 1'b1, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (b0.StallE !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_add_stall: got %b want 0", b0.StallE);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (b0.ALUResultM !== 32'd10 || b0.RD_M !== 5'd1) begin
            n_bad++;
            $display("FAIL b2b_add: got res=%0d rd=%0d want 10 1",
                     b0.ALUResultM, b0.RD_M);
        end
        for (int i = 0; i < 3; i++) begin
            drive(OP_MULHU, (i == 2) ? 32'h99 : 32'h0, 32'h0, 32'h104,
                  5'd2, 1'b1, 1'b0, 2'd0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (b0.StallE !== (i != 2)) begin
                n_bad++;
                $display("FAIL b2b_mulhu_stall%0d: got %b want %b",
                         i, b0.StallE, (i != 2));
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (b0.ALUResultM !== 32'h99 || b0.RD_M !== 5'd2) begin
            n_bad++;
            $display("FAIL b2b_mulhu: got res=%h rd=%0d want 99 2",
                     b0.ALUResultM, b0.RD_M);
        end
        drive(OP_SUB, 32'd3, 32'h0, 32'h108, 5'd8, 1'b1, 1'b0, 2'd2, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (b0.StallE !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_sub_stall: got %b want 0", b0.StallE);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (b0.ALUResultM !== 32'd3 || b0.RD_M !== 5'd8
            || b0.ResultSrcM !== 2'd2 || b0.PCPlus4M !== 32'h108) begin
            n_bad++;
            $display("FAIL b2b_sub: got res=%0d rd=%0d rs=%0d want 3 8 2",
                     b0.ALUResultM, b0.RD_M, b0.ResultSrcM);
        end
    endtask

    task automatic test_two_muls();
        logic [31:0] exp_res;
        logic        exp_stall;
        for (int i = 0; i < 6; i++) begin
            drive(OP_MUL, 32'd100 + 32'(i), 32'h0, 32'h200, 5'd6, 1'b1,
                  1'b0, 2'd0, 1'b0);
            exp_stall = (i % 3) != 2;
            exp_res = (i == 2) ? 32'd102 : (i == 5) ? 32'd105 : 32'd0;
            @(negedge clk);
            n_cmp++;
            if (b0.StallE !== exp_stall) begin
                n_bad++;
                $display("FAIL mul2_stall%0d: got %b want %b",
                         i, b0.StallE, exp_stall);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (b0.ALUResultM !== exp_res
                || b0.RegWriteM !== !exp_stall) begin
                n_bad++;
                $display("FAIL mul2_m%0d: got res=%0d rw=%b want %0d %b",
                         i, b0.ALUResultM, b0.RegWriteM, exp_res, !exp_stall);
            end
        end
    endtask

    task automatic test_flush();
        drive(OP_MULH, 32'hAA, 32'h0, 32'h300, 5'd7, 1'b1, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (b0.StallE !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_stall0: got %b want 1", b0.StallE);
        end
        @(posedge clk);
        #1;
        b0.FlushE = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b0.StallE !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_stall1: got %b want 0", b0.StallE);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (b0.MulBusy !== 1'b0 || b0.RegWriteM !== 1'b0
            || b0.ALUResultM !== 32'h0) begin
            n_bad++;
            $display("FAIL flush_idle: got busy=%b rw=%b res=%h want 0 0 0",
                     b0.MulBusy, b0.RegWriteM, b0.ALUResultM);
        end
        drive(OP_ADD, 32'hAA, 32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (b0.RegWriteM !== 1'b0 || b0.MulBusy !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_after%0d: got rw=%b busy=%b want 0 0",
                         i, b0.RegWriteM, b0.MulBusy);
            end
        end
    endtask

    task automatic test_store_and_lat1();
        drive(OP_ADD, 32'h1000, 32'hDEADBEEF, 32'h400, 5'd0, 1'b0, 1'b1,
              2'd0, 1'b0);
        b1.ALUControlE = OP_MUL;
        b1.ALUResultE  = 32'd77;
        b1.RD_E        = 5'd9;
        b1.RegWriteE   = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b1.StallE !== 1'b0) begin
            n_bad++;
            $display("FAIL lat1_stall: got %b want 0", b1.StallE);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (b0.MemWriteM !== 1'b1 || b0.WriteDataM !== 32'hDEADBEEF
            || b0.ALUResultM !== 32'h1000) begin
            n_bad++;
            $display("FAIL store: got mw=%b wd=%h want 1 deadbeef",
                     b0.MemWriteM, b0.WriteDataM);
        end
        n_cmp++;
        if (b1.ALUResultM !== 32'd77 || b1.RD_M !== 5'd9
            || b1.RegWriteM !== 1'b1 || b1.MulBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL lat1_mul: got res=%0d rd=%0d rw=%b want 77 9 1",
                     b1.ALUResultM, b1.RD_M, b1.RegWriteM);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(OP_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        b1.ALUControlE = OP_ADD;
        b1.ALUResultE  = '0;
        b1.WriteDataE  = '0;
        b1.PCPlus4E    = '0;
        b1.RD_E        = '0;
        b1.RegWriteE   = 1'b0;
        b1.MemWriteE   = 1'b0;
        b1.ResultSrcE  = '0;
        b1.FlushE      = 1'b0;
        #2;
        test_reset();
        test_reset_mid_wait();
        test_single_mul();
        test_back_to_back();
        test_two_muls();
        test_flush();
        test_store_and_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
